stage_transition: RTL and testbench

Sequences the screen transition between the World simulation and the VGA output path. It watches the World's `over` code, fades the 12-bit RGB `mask` to black, and holds black for a fixed time. It then pulses the World's reset, advances `stage` on a win, and fades back in. It sits downstream of World (`over`) and upstream of Output (`mask`) and World (`world_rstn`).

---
 rtl/stage_transition_pkg.sv | 25 ++
 rtl/stage_transition_if.sv | 30 +++
 rtl/stage_transition_frame_edge.sv | 29 ++
 rtl/stage_transition.sv | 147 ++++++++++++++
 tb/tb_stage_transition.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/stage_transition_pkg.sv
// Shared types and constants for the stage transition sequencer.
//   state_e  : sequencer states
//   OVER_*   : World status codes on the `over` bus
//   LVL_MAX  : full-brightness fade level
package stage_pkg;

   localparam int unsigned OVER_W = 2;
   localparam int unsigned LVL_W  = 4;
   localparam int unsigned MASK_W = 3 * LVL_W;

   typedef enum logic [2:0] {
      RUN,
      FADE_OUT,
      HOLD,
      RESET,
      FADE_IN
   } state_e;

   localparam logic [OVER_W-1:0] OVER_NONE = 2'b00;
   localparam logic [OVER_W-1:0] OVER_DEAD = 2'b01;
   localparam logic [OVER_W-1:0] OVER_WIN  = 2'b10;

   localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

endpackage

// File: rtl/stage_transition_if.sv
// World/Output-facing signal bundle of the stage transition sequencer.
//   frame_tick : frame-rate square wave into the sequencer
//   over       : World status into the sequencer
//   mask       : {R,G,B} brightness mask out to Output
//   world_rstn : active-low World reset
//   stage      : current level index
//   busy       : high whenever a transition is in progress
interface stage_transition_if;
   import stage_pkg::*;

   logic                frame_tick;
   logic [OVER_W-1:0]   over;
   logic [MASK_W-1:0]   mask;
   logic                world_rstn;
   logic                stage;
   logic                busy;

   // Environment side (World / Output / testbench).
   modport master (
      output frame_tick, over,
      input  mask, world_rstn, stage, busy
   );

   // Sequencer side.
   modport slave (
      input  frame_tick, over,
      output mask, world_rstn, stage, busy
   );

endinterface

// File: rtl/stage_transition_frame_edge.sv
// Two-flop sampler of the frame-rate square wave with a rising-edge pulse.
//   clk        : system clock
//   rstn       : synchronous active-low reset
//   frame_tick : asynchronous-ish frame square wave
//   tick       : one-clk pulse per rising edge of frame_tick
module frame_edge (
   input  logic clk,
   input  logic rstn,
   input  logic frame_tick,
   output logic tick
);

   logic f0_q;
   logic f1_q;

   // Sample stage plus delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         f0_q <= 1'b0;
         f1_q <= 1'b0;
      end else begin
         f0_q <= frame_tick;
         f1_q <= f0_q;
      end
   end

   assign tick = f0_q & ~f1_q;

endmodule

// File: rtl/stage_transition.sv
// Screen transition sequencer between World and the VGA output path:
// fades to black on a game-over, holds, resets World, bumps the stage on a
// win and fades back in.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : frame_tick/over in, mask/world_rstn/stage/busy out
module stage_transition
   import stage_pkg::*;
#(
   parameter int unsigned STEP_FRAMES = 2,
   parameter int unsigned HOLD_FRAMES = 30,
   parameter int unsigned RST_CYCLES  = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   stage_transition_if.slave    bus
);

   localparam int unsigned FRM_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
   localparam int unsigned FW      = $clog2(FRM_MAX) + 1;
   localparam int unsigned RW      = $clog2(RST_CYCLES) + 1;

   state_e             state_q, state_d;
   logic [LVL_W-1:0]   lvl_q, lvl_d;
   logic               wrst_q, wrst_d;
   logic               stage_q, stage_d;
   logic               win_q, win_d;
   logic               busy_q, busy_d;
   logic [FW-1:0]      frm_q, frm_d;
   logic [RW-1:0]      rcnt_q, rcnt_d;
   logic               tick;
   logic               step_c;

   frame_edge u_frame_edge (
      .clk        (clk),
      .rstn       (rstn),
      .frame_tick (bus.frame_tick),
      .tick       (tick)
   );

   // A step is the tick that completes a STEP_FRAMES count.
   assign step_c = tick && (frm_q == FW'(STEP_FRAMES - 1));

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      wrst_d  = wrst_q;
      stage_d = stage_q;
      win_d   = win_q;
      busy_d  = busy_q;
      frm_d   = frm_q;
      rcnt_d  = rcnt_q;

      unique case (state_q)
         RUN: begin
            lvl_d  = LVL_MAX;
            wrst_d = 1'b1;
            busy_d = 1'b0;
            if (bus.over != OVER_NONE) begin
               win_d   = (bus.over == OVER_WIN);
               frm_d   = '0;
               rcnt_d  = '0;
               busy_d  = 1'b1;
               state_d = FADE_OUT;
            end
         end
         FADE_OUT: begin
            if (tick) begin
               frm_d = step_c ? '0 : frm_q + FW'(1);
            end
            if (step_c) begin
               lvl_d = lvl_q - LVL_W'(1);
               if (lvl_q == LVL_W'(1)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (frm_q == FW'(HOLD_FRAMES - 1)) begin
                  frm_d   = '0;
                  rcnt_d  = '0;
                  wrst_d  = 1'b0;
                  stage_d = stage_q ^ win_q;
                  state_d = RESET;
               end else begin
                  frm_d = frm_q + FW'(1);
               end
            end
         end
         RESET: begin
            if (rcnt_q == RW'(RST_CYCLES - 1)) begin
               wrst_d  = 1'b1;
               frm_d   = '0;
               state_d = FADE_IN;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
         end
         FADE_IN: begin
            if (tick) begin
               frm_d = step_c ? '0 : frm_q + FW'(1);
            end
            if (step_c) begin
               lvl_d = lvl_q + LVL_W'(1);
               if (lvl_q == LVL_MAX - LVL_W'(1)) begin
                  busy_d  = 1'b0;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and output registers; reset keeps World held in reset too.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= RUN;
         lvl_q   <= LVL_MAX;
         wrst_q  <= 1'b0;
         stage_q <= 1'b0;
         win_q   <= 1'b0;
         busy_q  <= 1'b0;
         frm_q   <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         wrst_q  <= wrst_d;
         stage_q <= stage_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
         frm_q   <= frm_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign bus.mask       = {lvl_q, lvl_q, lvl_q};
   assign bus.world_rstn = wrst_q;
   assign bus.stage      = stage_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_stage_transition.sv
// Scoreboard bench for stage_transition: a sequence-level model pushes the
// expected output-change events; a monitor pops one per observed change.
module tb_stage_transition;

   localparam int STEP  = 1;
   localparam int HOLDF = 2;
   localparam int RSTC  = 4;
   localparam int TPER  = 16;   // clk cycles per frame_tick period

   typedef struct {
      logic [14:0] snap;   // {mask, world_rstn, stage, busy}
      int          delta;  // cycles since previous change, -1 = unchecked
      int          abs_cyc;// absolute cycle of change, -1 = unchecked
   } exp_t;

   logic        clk;
   logic        rstn;
   int          cyc;
   int          checks;
   int          errors;
   bit          mon_en;
   bit          m_stage;
   exp_t        sb[$];
   logic [14:0] cur_snap;

   stage_transition_if bus ();

   stage_transition #(
      .STEP_FRAMES (STEP),
      .HOLD_FRAMES (HOLDF),
      .RST_CYCLES  (RSTC)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   assign cur_snap = {bus.mask, bus.world_rstn, bus.stage, bus.busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      bus.frame_tick = 1'b0;
      #3;
      forever #(TPER * 5) bus.frame_tick = ~bus.frame_tick;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [14:0] mk(input int lvl, input bit wr, input bit st, input bit bz);
      logic [3:0] l;
      l = lvl[3:0];
      return {l, l, l, wr, st, bz};
   endfunction

   // Expected change events of one whole transition, from the level rules.
   task automatic build_seq(input logic [1:0] code, input int drive_cyc);
      bit   win;
      bit   s;
      exp_t e;
      win = (code == 2'b10);
      s   = m_stage;
      e.snap = mk(15, 1, s, 1); e.delta = -1; e.abs_cyc = drive_cyc + 1;
      sb.push_back(e);
      for (int l = 14; l >= 0; l--) begin
         e.snap = mk(l, 1, s, 1);
         e.delta = (l == 14) ? -1 : STEP * TPER;
         e.abs_cyc = -1;
         sb.push_back(e);
      end
      s = s ^ win;
      e.snap = mk(0, 0, s, 1); e.delta = HOLDF * TPER; e.abs_cyc = -1;
      sb.push_back(e);
      e.snap = mk(0, 1, s, 1); e.delta = RSTC;
      sb.push_back(e);
      for (int l = 1; l <= 15; l++) begin
         e.snap = mk(l, 1, s, (l != 15));
         e.delta = (l == 1) ? STEP * TPER - RSTC : STEP * TPER;
         sb.push_back(e);
      end
      m_stage = s;
   endtask

   // Monitor: every output change must match the next expected event.
   initial begin
      logic [14:0] prev;
      int          last;
      exp_t        e;
      @(negedge clk);
      prev = cur_snap;
      last = cyc;
      forever begin
         @(negedge clk);
         if (cur_snap !== prev) begin
            if (mon_en) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_change got %h want no change (cycle %0d)", cur_snap, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("out_event", 32'(cur_snap), 32'(e.snap));
                  if (e.delta >= 0) chk("event_gap", cyc - last, e.delta);
                  if (e.abs_cyc >= 0) chk("busy_latency", cyc, e.abs_cyc);
               end
            end
            prev = cur_snap;
            last = cyc;
         end
      end
   end

   task automatic wait_mask(input logic [11:0] target);
      int n = 0;
      while (bus.mask !== target && n < 800) begin
         @(negedge clk); #1;
         n++;
      end
      chk("mask_reach", 32'(bus.mask), 32'(target));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("seq_done", sb.size(), 0);
   endtask

   task automatic run_seq(input logic [1:0] code, input bit poke);
      @(negedge clk); #1;
      build_seq(code, cyc);
      bus.over = code;
      @(negedge clk); #1;
      bus.over = 2'b00;
      if (poke) begin
         wait_mask(12'hAAA);
         bus.over = 2'b10;
         repeat (5) @(negedge clk);
         #1;
         bus.over = 2'b00;
      end
      wait_drain();
      repeat ($urandom_range(10, 60)) @(negedge clk);
   endtask

   task automatic check_idle_reset(input string nm);
      chk({nm, "_mask"}, 32'(bus.mask), 32'h0000_0FFF);
      chk({nm, "_wrstn"}, 32'(bus.world_rstn), 32'd0);
      chk({nm, "_stage"}, 32'(bus.stage), 32'd0);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      mon_en  = 1'b0;
      m_stage = 1'b0;
      rstn    = 1'b0;
      bus.over = 2'b00;

      // Reset values, then World released one cycle after rstn.
      repeat (5) @(negedge clk);
      check_idle_reset("reset");
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("release_wrstn", 32'(bus.world_rstn), 32'd1);
      chk("release_mask", 32'(bus.mask), 32'h0000_0FFF);
      mon_en = 1'b1;

      run_seq(2'b01, 1'b0);      // death
      run_seq(2'b10, 1'b0);      // win: stage 0 -> 1
      run_seq(2'b01, 1'b1);      // death with over=10 poked during fade-out
      repeat (100) @(negedge clk);

      // Abort mid fade-out after a win.
      @(negedge clk); #1;
      build_seq(2'b01, cyc);
      bus.over = 2'b01;
      @(negedge clk); #1;
      bus.over = 2'b00;
      wait_mask(12'h777);
      mon_en = 1'b0;
      sb.delete();
      rstn = 1'b0;
      @(negedge clk);
      check_idle_reset("abort");
      m_stage = 1'b0;
      repeat (3) @(negedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("abort_release_wrstn", 32'(bus.world_rstn), 32'd1);
      mon_en = 1'b1;

      run_seq(2'b11, 1'b0);      // 11 treated as dead
      run_seq(2'b10, 1'b0);      // win -> 1
      run_seq(2'b10, 1'b0);      // second win wraps -> 0
      for (int i = 0; i < 3; i++) begin
         run_seq(2'($urandom_range(1, 3)), 1'b0);
      end
      repeat (50) @(negedge clk);
      chk("final_stage", 32'(bus.stage), 32'(m_stage));
      chk("final_queue", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
